// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access pipeline stage: access sizes, FSM states,
// byte-enable patterns and the load-lane extension helper.
package mem_access_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Sign- or zero-extend a byte (lane[7:0]) or a half (lane[15:0]) to 32 bits.
    function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                                input logic        is_half,
                                                input logic        zero_ext);
        logic sgn;
        sgn = zero_ext ? 1'b0 : (is_half ? lane[15] : lane[7]);
        if (is_half) begin
            return {{16{sgn}}, lane};
        end else begin
            return {{24{sgn}}, lane[7:0]};
        end
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response port. The stage drives it through the master
// modport; the memory side uses the slave modport.
interface mem_access_stage_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_access_stage_lane.sv
// Combinational lane logic: store replication, byte enables, load extract/extend and
// misalign detection (active only when MEM_ALIGN_CHECK_EN is defined).
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    input  logic        i_unsigned,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    // Lane steering; misaligned low bits simply drop out of the half/word cases.
    always_comb begin
        o_wdata     = i_store_data;
        o_be        = BE_WORD;
        o_load_data = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_wdata     = {4{i_store_data[7:0]}};
                o_be        = BE_BYTE0 << i_addr_lo;
                o_load_data = extend_lane({8'h00, i_rdata[{i_addr_lo, 3'b000} +: 8]},
                                          1'b0, i_unsigned);
            end
            SZ_HALF: begin
                o_wdata     = {2{i_store_data[15:0]}};
                o_be        = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                o_load_data = extend_lane(i_rdata[{i_addr_lo[1], 4'b0000} +: 16],
                                          1'b1, i_unsigned);
            end
            SZ_WORD: begin
                o_wdata     = i_store_data;
                o_be        = BE_WORD;
                o_load_data = i_rdata;
            end
            default: begin
                o_wdata     = i_store_data;
                o_be        = BE_WORD;
                o_load_data = i_rdata;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Halves need an even address, words a word-aligned one.
    always_comb begin
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: o_misalign = 1'b0;
            SZ_HALF: o_misalign = i_addr_lo[0];
            default: o_misalign = (i_addr_lo != 2'b00);
        endcase
    end
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: IDLE/REQ/RESP FSM, stall generation, registered
// writeback bundle. Optional misalign exceptions with MEM_ALIGN_CHECK_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [31:0]           in_alu_result,
    input  logic [31:0]           in_store_data,
    input  logic [REG_W-1:0]      in_write_reg,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    output logic                  stall,
    mem_access_stage_if.master    mem,
    output logic                  wb_valid,
    output logic [REG_W-1:0]      wb_reg,
    output logic                  wb_reg_write,
    output logic [31:0]           wb_data,
    output logic                  misalign_exc,
    output logic [31:0]           exc_addr
);

    state_t            r_state;
    logic [31:0]       r_alu;
    logic [REG_W-1:0]  r_reg;
    logic              r_reg_write;
    logic              r_is_store;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_req_valid;
    logic              r_req_we;
    logic [ADDR_W-1:0] r_req_addr;
    logic [31:0]       r_req_wdata;
    logic [3:0]        r_req_be;
    logic              r_wb_valid;
    logic [REG_W-1:0]  r_wb_reg;
    logic              r_wb_reg_write;
    logic [31:0]       r_wb_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic              r_misalign_exc;
    logic [31:0]       r_exc_addr;
`endif

    logic              w_is_mem;
    logic [1:0]        w_lane_size;
    logic [1:0]        w_lane_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic [31:0]       w_load_data;
    logic              w_misalign;

    assign w_is_mem = in_mem_read | in_mem_write;

    // In IDLE the lane logic sees the incoming op; afterwards the latched access.
    assign w_lane_size = (r_state == ST_IDLE) ? in_size : r_size;
    assign w_lane_addr = (r_state == ST_IDLE) ? in_alu_result[1:0] : r_alu[1:0];

    mem_lane_align u_lane (
        .i_size       (w_lane_size),
        .i_addr_lo    (w_lane_addr),
        .i_store_data (in_store_data),
        .i_rdata      (mem.rsp_rdata),
        .i_unsigned   (r_unsigned),
        .o_wdata      (w_wdata),
        .o_be         (w_be),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign)
    );

    assign stall = (r_state != ST_IDLE) || (in_valid && w_is_mem && !w_misalign);

    // Access FSM with registered request and writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_alu          <= 32'h0;
            r_reg          <= '0;
            r_reg_write    <= 1'b0;
            r_is_store     <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_req_valid    <= 1'b0;
            r_req_we       <= 1'b0;
            r_req_addr     <= '0;
            r_req_wdata    <= 32'h0;
            r_req_be       <= 4'h0;
            r_wb_valid     <= 1'b0;
            r_wb_reg       <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misalign_exc <= 1'b0;
            r_exc_addr     <= 32'h0;
`endif
        end else begin
            r_wb_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misalign_exc <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_alu       <= in_alu_result;
                        r_reg       <= in_write_reg;
                        r_reg_write <= in_reg_write;
                        r_is_store  <= in_mem_write;
                        r_size      <= in_size;
                        r_unsigned  <= in_unsigned;
                        if (!w_is_mem) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_reg       <= in_write_reg;
                            r_wb_reg_write <= in_reg_write;
                            r_wb_data      <= in_alu_result;
                        end
`ifdef MEM_ALIGN_CHECK_EN
                        else if (w_misalign) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_reg       <= in_write_reg;
                            r_wb_reg_write <= 1'b0;
                            r_wb_data      <= in_alu_result;
                            r_misalign_exc <= 1'b1;
                            r_exc_addr     <= in_alu_result;
                        end
`endif
                        else begin
                            r_req_valid <= 1'b1;
                            r_req_we    <= in_mem_write;
                            r_req_addr  <= {in_alu_result[ADDR_W-1:2], 2'b00};
                            r_req_wdata <= w_wdata;
                            r_req_be    <= w_be;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.req_ready) begin
                        r_req_valid <= 1'b0;
                        r_req_we    <= 1'b0;
                        if (r_is_store) begin
                            r_wb_valid     <= 1'b1;
                            r_wb_reg       <= r_reg;
                            r_wb_reg_write <= 1'b0;
                            r_wb_data      <= r_alu;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (mem.rsp_valid) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_reg       <= r_reg;
                        r_wb_reg_write <= r_reg_write;
                        r_wb_data      <= w_load_data;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_req_we    <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.req_valid = r_req_valid;
    assign mem.req_we    = r_req_we;
    assign mem.req_addr  = r_req_addr;
    assign mem.req_wdata = r_req_wdata;
    assign mem.req_be    = r_req_be;

    assign wb_valid     = r_wb_valid;
    assign wb_reg       = r_wb_reg;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_data      = r_wb_data;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_exc = r_misalign_exc;
    assign exc_addr     = r_exc_addr;
`else
    assign misalign_exc = 1'b0;
    assign exc_addr     = 32'h0;
`endif

endmodule
